// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline controller slice.
// Holds the FSM state encodings, host command encodings and the
// byte-per-word address shift used when forming instruction-memory addresses.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_ABORT = 2'd3
  } cmd_e;

  // Instruction words are 4 bytes wide: byte address = word index << 2.
  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/pipeline_ctrl_loader.sv
// Instruction-memory loader: owns the word index, latched load length and
// the registered instruction-memory write port.
// Ports:
//   i_clk, i_reset (async active-low)
//   i_start      : latch clipped length and clear the word index
//   i_load_len   : requested word count (sampled with i_start)
//   i_word_fire  : a load word was accepted this cycle
//   i_word       : the accepted load word
//   o_last_c     : current index is the final word of the load
//   o_imem_we/o_imem_addr/o_imem_data : registered write port
module pipeline_ctrl_loader
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [$clog2(IMEM_DEPTH):0]   i_load_len,
  input  logic                          i_word_fire,
  input  logic [DATA_W-1:0]             i_word,
  output logic                          o_last_c,
  output logic                          o_imem_we,
  output logic [ADDR_W-1:0]             o_imem_addr,
  output logic [DATA_W-1:0]             o_imem_data
);

  localparam int unsigned LEN_W = $clog2(IMEM_DEPTH) + 1;

  logic [LEN_W-1:0]  idx_q, len_q, len_clip_c;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Requests longer than the memory are clipped to its depth.
  assign len_clip_c = (i_load_len > LEN_W'(IMEM_DEPTH)) ? LEN_W'(IMEM_DEPTH) : i_load_len;
  assign o_last_c   = ((idx_q + LEN_W'(1)) == len_q);

  // Index/length bookkeeping and the one-cycle-delayed write port.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      idx_q  <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= i_word_fire;
      if (i_start) begin
        len_q <= len_clip_c;
        idx_q <= '0;
      end else if (i_word_fire) begin
        idx_q  <= idx_q + LEN_W'(1);
        addr_q <= ADDR_W'(idx_q) << WORD_SHIFT;
        data_q <= i_word;
      end
    end
  end

  assign o_imem_we   = we_q;
  assign o_imem_addr = addr_q;
  assign o_imem_data = data_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: accepts host commands to load instruction memory,
// run until a HALT retires, or single-step, and freezes the pipeline otherwise.
// Optional feature macro: PIPELINE_CTRL_CYCLE_CNT_EN enables the saturating
// unfrozen-cycle counter; without it o_cycle_count is tied to zero.
// Ports: i_clk, i_reset (async active-low); command handshake
// (i_cmd_valid, i_cmd, i_load_len, o_cmd_ready); load-word handshake
// (i_word_valid, i_word, o_word_ready); imem write port (o_imem_we,
// o_imem_addr, o_imem_data); o_halt freeze, i_halt_seen; status
// (o_state, o_done, o_cmd_err, o_cycle_count).
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_cmd_valid,
  input  logic [1:0]                  i_cmd,
  input  logic [$clog2(IMEM_DEPTH):0] i_load_len,
  output logic                        o_cmd_ready,
  input  logic                        i_word_valid,
  input  logic [DATA_W-1:0]           i_word,
  output logic                        o_word_ready,
  output logic                        o_imem_we,
  output logic [ADDR_W-1:0]           o_imem_addr,
  output logic [DATA_W-1:0]           o_imem_data,
  output logic                        o_halt,
  input  logic                        i_halt_seen,
  output logic [2:0]                  o_state,
  output logic                        o_done,
  output logic                        o_cmd_err,
  output logic [CNT_W-1:0]            o_cycle_count
);

  state_e state_q, state_d;
  logic   halt_q, halt_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   word_ready_q, word_ready_d;
  logic   load_start_c, word_fire_c, last_c;
  logic   is_abort_c;

  assign is_abort_c = i_cmd_valid && (cmd_e'(i_cmd) == CMD_ABORT);

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    load_start_c = 1'b0;
    word_fire_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (cmd_e'(i_cmd) == CMD_LOAD) begin
            load_start_c = 1'b1;
            // Zero-length load completes immediately without entering LOAD.
            if (i_load_len == '0) done_d  = 1'b1;
            else                  state_d = ST_LOAD;
          end else if (cmd_e'(i_cmd) == CMD_RUN) begin
            state_d = ST_RUN;
          end else if (cmd_e'(i_cmd) == CMD_STEP) begin
            state_d = ST_STEP;
          end
        end
      end
      ST_LOAD: begin
        // ABORT wins over a coincident word; that word is discarded.
        if (is_abort_c) begin
          state_d = ST_IDLE;
        end else begin
          err_d = i_cmd_valid;
          if (i_word_valid && word_ready_q) begin
            word_fire_c = 1'b1;
            if (last_c) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (is_abort_c) begin
          state_d = ST_IDLE;
        end else begin
          err_d = i_cmd_valid;
          if (i_halt_seen) state_d = ST_DONE;
        end
      end
      ST_STEP: begin
        if (is_abort_c) begin
          state_d = ST_IDLE;
        end else begin
          err_d   = i_cmd_valid;
          state_d = i_halt_seen ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        err_d   = i_cmd_valid && !is_abort_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_DONE) done_d = 1'b1;
    halt_d       = !((state_d == ST_RUN) || (state_d == ST_STEP));
    word_ready_d = (state_d == ST_LOAD);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      halt_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_q       <= halt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_ready_q <= word_ready_d;
    end
  end

  pipeline_ctrl_loader #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_loader (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (load_start_c),
    .i_load_len  (i_load_len),
    .i_word_fire (word_fire_c),
    .i_word      (i_word),
    .o_last_c    (last_c),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_data (o_imem_data)
  );

`ifdef PIPELINE_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of unfrozen cycles, cleared by each accepted LOAD.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (load_start_c) begin
      cnt_q <= '0;
    end else if (!halt_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_cycle_count = cnt_q;
`else
  assign o_cycle_count = '0;
`endif

  assign o_cmd_ready  = 1'b1;
  assign o_word_ready = word_ready_q;
  assign o_halt       = halt_q;
  assign o_done       = done_q;
  assign o_cmd_err    = err_q;
  assign o_state      = 3'(state_q);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected imem writes are queued by the
// stimulus and popped by a negedge monitor; FSM status is checked directly.
module tb_pipeline_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned LEN_W  = $clog2(DEPTH) + 1;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_cmd_valid;
  logic [1:0]        i_cmd;
  logic [LEN_W-1:0]  i_load_len;
  logic              o_cmd_ready;
  logic              i_word_valid;
  logic [DATA_W-1:0] i_word;
  logic              o_word_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [DATA_W-1:0] o_imem_data;
  logic              o_halt;
  logic              i_halt_seen;
  logic [2:0]        o_state;
  logic              o_done;
  logic              o_cmd_err;
  logic [CNT_W-1:0]  o_cycle_count;

  pipeline_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_load_len(i_load_len), .o_cmd_ready(o_cmd_ready), .i_word_valid(i_word_valid),
    .i_word(i_word), .o_word_ready(o_word_ready), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data), .o_halt(o_halt),
    .i_halt_seen(i_halt_seen), .o_state(o_state), .o_done(o_done),
    .o_cmd_err(o_cmd_err), .o_cycle_count(o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              done;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;

`ifdef PIPELINE_CTRL_CYCLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c, input int len);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    i_load_len  = LEN_W'(len);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic push_wr(input int idx, input logic [DATA_W-1:0] d, input logic dn);
    wr_t w;
    w.addr = ADDR_W'(idx * 4);
    w.data = d;
    w.done = dn;
    exp_q.push_back(w);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (o_done)    done_cnt++;
    if (o_cmd_err) err_cnt++;
    if (o_imem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(o_imem_addr), 64'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 64'(o_imem_addr), 64'(w.addr));
        chk("wr_data", 64'(o_imem_data), 64'(w.data));
        chk("wr_done", 64'(o_done), 64'(w.done));
      end
    end
  end

  initial begin
    int d0, e0;
    i_reset = 1'b0; i_cmd_valid = 1'b0; i_cmd = 2'd0; i_load_len = '0;
    i_word_valid = 1'b0; i_word = '0; i_halt_seen = 1'b0;
    #12;
    chk("rst_state", 64'(o_state), 64'(3'd0));
    chk("rst_halt", 64'(o_halt), 64'd1);
    chk("rst_we", 64'(o_imem_we), 64'd0);
    chk("rst_word_ready", 64'(o_word_ready), 64'd0);
    chk("cmd_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_count", 64'(o_cycle_count), 64'd0);
    i_reset = 1'b1;
    tick();

    // LOAD len=3, back-to-back words
    d0 = done_cnt;
    send_cmd(2'd0, 3);
    chk("load3_state", 64'(o_state), 64'(3'd1));
    chk("load3_wready", 64'(o_word_ready), 64'd1);
    chk("load3_halt", 64'(o_halt), 64'd1);
    for (int i = 0; i < 3; i++) push_wr(i, 32'hAAAA_0001 + 32'(i), (i == 2));
    for (int i = 0; i < 3; i++) begin
      i_word_valid = 1'b1; i_word = 32'hAAAA_0001 + 32'(i);
      tick();
    end
    i_word_valid = 1'b0;
    chk("load3_idle", 64'(o_state), 64'(3'd0));
    tick();
    chk("load3_drained", 64'(exp_q.size()), 64'd0);
    chk("load3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // LOAD clipped to memory depth
    send_cmd(2'd0, DEPTH + 5);
    for (int i = 0; i < int'(DEPTH); i++) push_wr(i, 32'hB000_0000 + 32'(i), (i == int'(DEPTH) - 1));
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      i_word_valid = 1'b1; i_word = 32'hB000_0000 + 32'(i);
      tick();
    end
    i_word_valid = 1'b0;
    chk("clip_idle", 64'(o_state), 64'(3'd0));
    chk("clip_wready", 64'(o_word_ready), 64'd0);
    chk("clip_drained", 64'(exp_q.size()), 64'd0);

    // RUN, HALT retires after 10 unfrozen cycles
    d0 = done_cnt;
    send_cmd(2'd1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("run_halt_low", 64'(o_halt), 64'd0);
      chk("run_state", 64'(o_state), 64'(3'd2));
      if (i == 9) i_halt_seen = 1'b1;
      tick();
    end
    chk("run_done_state", 64'(o_state), 64'(3'd4));
    chk("run_done_pulse", 64'(o_done), 64'd1);
    chk("run_done_halt", 64'(o_halt), 64'd1);
    chk("run_count", 64'(o_cycle_count), CNT_ON ? 64'd10 : 64'd0);
    tick();
    i_halt_seen = 1'b0;
    chk("run_back_idle", 64'(o_state), 64'(3'd0));
    chk("run_done_once", 64'(done_cnt - d0), 64'd1);

    // Zero-length LOAD clears the counter and completes at once
    send_cmd(2'd0, 0);
    chk("len0_state", 64'(o_state), 64'(3'd0));
    chk("len0_done", 64'(o_done), 64'd1);
    chk("len0_count", 64'(o_cycle_count), 64'd0);
    tick();
    chk("len0_done_gone", 64'(o_done), 64'd0);

    // STEP x3
    for (int i = 0; i < 3; i++) begin
      send_cmd(2'd2, 0);
      chk("step_state", 64'(o_state), 64'(3'd3));
      chk("step_halt_low", 64'(o_halt), 64'd0);
      tick();
      chk("step_idle", 64'(o_state), 64'(3'd0));
      chk("step_halt_high", 64'(o_halt), 64'd1);
    end
    chk("step_count", 64'(o_cycle_count), CNT_ON ? 64'd3 : 64'd0);

    // ABORT coincident with the second word
    d0 = done_cnt;
    send_cmd(2'd0, 4);
    push_wr(0, 32'hC0DE_0000, 1'b0);
    i_word_valid = 1'b1; i_word = 32'hC0DE_0000;
    tick();
    i_word = 32'hC0DE_0001; i_cmd_valid = 1'b1; i_cmd = 2'd3;
    tick();
    i_word_valid = 1'b0; i_cmd_valid = 1'b0;
    chk("abort_idle", 64'(o_state), 64'(3'd0));
    tick();
    chk("abort_drained", 64'(exp_q.size()), 64'd0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // RUN offered during LOAD is rejected, load continues
    e0 = err_cnt;
    send_cmd(2'd0, 2);
    push_wr(0, 32'hD000_0000, 1'b0);
    push_wr(1, 32'hD000_0001, 1'b1);
    i_word_valid = 1'b1; i_word = 32'hD000_0000; i_cmd_valid = 1'b1; i_cmd = 2'd1;
    tick();
    i_cmd_valid = 1'b0;
    chk("err_pulse", 64'(o_cmd_err), 64'd1);
    chk("err_still_load", 64'(o_state), 64'(3'd1));
    i_word = 32'hD000_0001;
    tick();
    i_word_valid = 1'b0;
    chk("err_load_idle", 64'(o_state), 64'(3'd0));
    tick();
    chk("err_once", 64'(err_cnt - e0), 64'd1);
    chk("err_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-RUN, then first command right after release
    send_cmd(2'd1, 0);
    tick(); tick();
    #2;
    i_reset = 1'b0;
    #1;
    chk("arst_state", 64'(o_state), 64'(3'd0));
    chk("arst_halt", 64'(o_halt), 64'd1);
    chk("arst_count", 64'(o_cycle_count), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    i_reset = 1'b1;
    send_cmd(2'd1, 0);
    chk("post_rst_run", 64'(o_state), 64'(3'd2));
    send_cmd(2'd3, 0);
    chk("abort_run_idle", 64'(o_state), 64'(3'd0));
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 32, instruction-memory byte-address width.
REQ-003 SHALL have parameter IMEM_DEPTH, default 256, loadable words (power of two, >=2).
REQ-004 SHALL have parameter CNT_W, default 32, cycle-counter width.
REQ-005 SHALL have ports:
- i_clk, in, 1: single clock, rising edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_cmd_valid, in, 1: command offered.
- i_cmd, in, 2: 0=LOAD, 1=RUN, 2=STEP, 3=ABORT.
- i_load_len, in, $clog2(IMEM_DEPTH)+1: word count, sampled with LOAD.
- o_cmd_ready, out, 1: command accepted when high with i_cmd_valid.
- i_word_valid, in, 1: load word offered.
- i_word, in, DATA_W: load word.
- o_word_ready, out, 1: word accepted when high with i_word_valid.
- o_imem_we, out, 1: instruction-memory write strobe.
- o_imem_addr, out, ADDR_W: write byte address.
- o_imem_data, out, DATA_W: write data.
- o_halt, out, 1: pipeline freeze; high means frozen.
- i_halt_seen, in, 1: HALT instruction retired at WB.
- o_state, out, 3: current FSM state encoding.
- o_done, out, 1: one-cycle completion pulse.
- o_cmd_err, out, 1: one-cycle pulse on a rejected command.
- o_cycle_count, out, CNT_W: unfrozen cycles since last LOAD.

Function
REQ-006 FSM states SHALL be IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4.
REQ-007 o_cmd_ready SHALL be 1 in every state; a command is accepted on i_cmd_valid & o_cmd_ready.
REQ-008 In IDLE: LOAD goes to LOAD, RUN goes to RUN, STEP goes to STEP, ABORT is a no-op.
REQ-009 On LOAD acceptance, length SHALL latch as min(i_load_len, IMEM_DEPTH) and the word index SHALL clear to 0.
REQ-010 LOAD with latched length 0 SHALL pulse o_done the next cycle and return to IDLE with no write.
REQ-011 In LOAD, o_word_ready SHALL be 1; each accepted word SHALL produce one registered write the following cycle:
- o_imem_we=1
- o_imem_addr = index*4, zero-extended to ADDR_W
- o_imem_data = the accepted word
REQ-012 After the last word is accepted, the FSM SHALL go to IDLE, with o_done pulsing in the same cycle as the final o_imem_we.
REQ-013 o_halt SHALL be 0 only in RUN and STEP, and 1 in IDLE, LOAD and DONE.
REQ-014 RUN SHALL hold until i_halt_seen=1, then go to DONE.
REQ-015 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-016 STEP SHALL last exactly one cycle, then go to IDLE; if i_halt_seen=1 in that cycle, it SHALL go to DONE instead.
REQ-017 ABORT accepted in LOAD, RUN or STEP SHALL return the FSM to IDLE next cycle without an o_done pulse.
REQ-018 In LOAD, ABORT SHALL take priority over a simultaneous word handshake; that word SHALL be discarded (no write).
REQ-019 Any non-ABORT command accepted outside IDLE SHALL be dropped and SHALL pulse o_cmd_err for one cycle.
REQ-020 i_halt_seen SHALL be ignored outside RUN and STEP.
REQ-021 o_word_ready SHALL be 0 outside LOAD.
REQ-022 o_imem_we SHALL be 0 in every cycle not following an accepted word.

Reset
REQ-023 Asserting i_reset low SHALL immediately force the following, regardless of state (including mid-LOAD or mid-RUN):
- state IDLE
- o_halt=1
- o_imem_we=0, o_imem_addr=0, o_imem_data=0
- o_done=0, o_cmd_err=0
- o_cycle_count=0
- word index and latched length cleared
REQ-024 Release SHALL be sampled synchronously; the first command SHALL be accepted on the first rising edge after release.

Configuration
REQ-025 With PIPELINE_CTRL_CYCLE_CNT_EN defined:
- o_cycle_count SHALL increment once per cycle with o_halt=0.
- It SHALL saturate at all-ones.
- It SHALL clear on LOAD acceptance.
REQ-026 Without PIPELINE_CTRL_CYCLE_CNT_EN, o_cycle_count SHALL be constant 0 and no counter flops SHALL be synthesised.

Structure
REQ-027 A shared package pipeline_pkg SHALL hold:
- the state encodings
- the command encodings (CMD_LOAD, CMD_RUN, CMD_STEP, CMD_ABORT)
- the byte-per-word shift constant (2)
REQ-028 The block SHALL have one sub-module, pipeline_ctrl_loader, owning the word index, latched length and registered write port; the FSM and counter SHALL stay in pipeline_ctrl.

Verification
REQ-029 The bench SHALL cover these scenarios:
- LOAD len=3, words 0xAAAA0001..0xAAAA0003 back-to-back -> writes at addr 0x0, 0x4, 0x8, o_done on the third write, then IDLE.
- LOAD len=IMEM_DEPTH+5 -> exactly IMEM_DEPTH writes, last addr (IMEM_DEPTH-1)*4.
- RUN, i_halt_seen after 10 cycles -> o_halt=0 for 10 cycles, DONE for one cycle with o_done=1, o_cycle_count=10 (macro on) or 0 (macro off).
- STEP x3 -> o_halt low for exactly 1 cycle each, o_cycle_count=3.
- ABORT simultaneous with the 2nd word of LOAD len=4 -> one write only, IDLE, no o_done.
- RUN during LOAD -> o_cmd_err pulse, load continues; reset asserted mid-RUN -> o_halt=1 and IDLE with no clock edge.
